// File: rtl/btn_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_arbiter_pkg
//  Description : Shared constants and helpers for the push-button event
//                arbiter (debounce length defaults, counter width function).
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_event_arbiter_pkg;

    // 10 ms of stable level at 50 MHz
    localparam int c_deb_cycles_def = 500000;
    // Short debounce used when the block is simulated
    localparam int c_deb_cycles_sim = 4;

    // Number of bits needed to count 0 .. value-1 (at least 1)
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_event_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_arbiter_if
//  Description : valid/ready event channel carrying the index of a pressed
//                button from the arbiter to the application FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/btn_event_arbiter_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_arbiter_debounce
//  Description : One button: 2-flop synchronizer, stable-level debounce
//                counter, debounced level and a one-cycle press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_arbiter_debounce
    import btn_event_arbiter_pkg::*;
#(
    parameter int DEB_CYCLES = c_deb_cycles_def
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_press
);

    localparam int                 c_cnt_w   = clog2(DEB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_press;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES cycles;
    // the press pulse is registered on the same edge the level rises
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
                r_press <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_arbiter
//  Description : Debounces NUM_BTN push-buttons, queues one event per press
//                and round-robin arbitrates them onto a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_arbiter
    import btn_event_arbiter_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int DEB_CYCLES = c_deb_cycles_def,
    parameter int ID_W       = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [NUM_BTN-1:0] btn,
    input  wire logic               ovr_clr,
    output logic      [NUM_BTN-1:0] btn_level,
    output logic                    overrun,
    btn_event_arbiter_if.master     evt
);

    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] r_pending;
    logic [ID_W-1:0]    r_rr;
    logic               r_valid;
    logic [ID_W-1:0]    r_id;
    logic               r_overrun;

    logic [ID_W-1:0]    w_grant;
    logic               w_found;
    logic               w_load;
    logic [NUM_BTN-1:0] w_clr;
    logic               w_drop;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
        btn_event_arbiter_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_btn   (btn[gi]),
            .o_level (btn_level[gi]),
            .o_press (w_press[gi])
        );
    end

    // Round-robin pick: first pending bit after r_rr, wrapping; scanning from
    // the far end lets the nearest candidate overwrite the others
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = NUM_BTN; k >= 1; k--) begin
            if (r_pending[(int'(r_rr) + k) % NUM_BTN]) begin
                w_found = 1'b1;
                w_grant = ID_W'((int'(r_rr) + k) % NUM_BTN);
            end
        end
    end

    // Slot reload condition, the pending bit it consumes, and dropped presses
    always_comb begin
        w_load = !r_valid || evt.evt_ready;
        w_clr  = '0;
        if (w_load && w_found) begin
            w_clr[w_grant] = 1'b1;
        end
        w_drop = |(w_press & r_pending & ~w_clr);
    end

    // Pending set, output slot, rr pointer and sticky overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_rr      <= ID_W'(NUM_BTN - 1);
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_press;
            if (w_load) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_id    <= w_grant;
                    r_rr    <= w_grant;
                end else begin
                    r_valid <= 1'b0;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = r_valid;
    assign evt.evt_id    = r_id;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire
